// File: rtl/serial_adder_ctrl_if.sv
// ----------------------------------------------------------------------------
// serial_adder_ctrl_if
//   Operand/result handshake bundle between an operand source/result consumer
//   and the serial_adder_ctrl sequencer.
//
//   Signals
//     start_valid   source -> ctrl   operands a/b/cin valid
//     start_ready   ctrl -> source   controller can accept operands
//     a, b          source -> ctrl   WIDTH-bit operands
//     cin           source -> ctrl   carry-in for bit 0
//     result_valid  ctrl -> consumer sum/cout/ovf valid
//     result_ready  consumer -> ctrl consumer accepts result
//     sum           ctrl -> consumer A+B+cin, low WIDTH bits
//     cout          ctrl -> consumer carry out of bit WIDTH-1
//     ovf           ctrl -> consumer signed overflow
//
//   Modports
//     master  operand source / result consumer side
//     slave   serial_adder_ctrl side
// ----------------------------------------------------------------------------
interface serial_adder_ctrl_if #(
   parameter int WIDTH = 8
);
   logic             start_valid;
   logic             start_ready;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             cin;
   logic             result_valid;
   logic             result_ready;
   logic [WIDTH-1:0] sum;
   logic             cout;
   logic             ovf;

   modport master (
      output start_valid,
      output a,
      output b,
      output cin,
      output result_ready,
      input  start_ready,
      input  result_valid,
      input  sum,
      input  cout,
      input  ovf
   );

   modport slave (
      input  start_valid,
      input  a,
      input  b,
      input  cin,
      input  result_ready,
      output start_ready,
      output result_valid,
      output sum,
      output cout,
      output ovf
   );
endinterface : serial_adder_ctrl_if

// File: rtl/serial_adder_ctrl.sv
// ----------------------------------------------------------------------------
// serial_adder_ctrl
//   Sequencer that time-shares one external 1-bit full adder across a
//   WIDTH-bit addition. Operands arrive over a valid/ready handshake, the
//   adder is driven one bit per clock LSB first with the carry rippled
//   through a register, and the sum/carry-out leave over a second
//   valid/ready handshake. Latency is WIDTH cycles from accept to
//   result_valid; with result_ready tied high one add completes every
//   WIDTH+2 cycles.
//
//   Parameters
//     WIDTH   operand/sum width in bits (>= 2)
//
//   Ports
//     clk      input   system clock, rising edge
//     rst_n    input   asynchronous active-low reset
//     bus      slave   operand/result handshake (serial_adder_ctrl_if)
//     fa_in1   output  to full adder input 1 (bit of A)
//     fa_in2   output  to full adder input 2 (bit of B)
//     fa_cin   output  to full adder carry-in
//     fa_sum   input   full adder sum (combinational)
//     fa_cout  input   full adder carry-out (combinational)
//     busy     output  high while an add is running or its result is held
//
//   Configuration
//     SERIAL_ADDER_OVF_EN  when defined, a register captures the carry into
//                          the MSB XOR the carry out of the MSB, giving the
//                          two's-complement overflow flag on bus.ovf. When
//                          undefined, bus.ovf is tied low.
// ----------------------------------------------------------------------------
module serial_adder_ctrl #(
   parameter int WIDTH = 8
) (
   input  logic                clk,
   input  logic                rst_n,
   serial_adder_ctrl_if.slave  bus,
   output logic                fa_in1,
   output logic                fa_in2,
   output logic                fa_cin,
   input  logic                fa_sum,
   input  logic                fa_cout,
   output logic                busy
);

   localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_RUN  = 2'b01,
      ST_DONE = 2'b10
   } state_t;

   state_t           state_r;
   state_t           state_nxt_s;
   logic             accept_s;
   logic             last_step_s;

   logic [CNT_W-1:0] cnt_r;
   logic [WIDTH-1:0] a_sh_r;
   logic [WIDTH-1:0] b_sh_r;
   logic [WIDTH-1:0] sum_sh_r;
   logic             carry_r;

   logic             start_ready_r;
   logic             result_valid_r;
   logic             busy_r;

   // FSM state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // FSM next-state decode and step strobes for the datapath
   always_comb begin
      state_nxt_s = state_r;
      accept_s    = 1'b0;
      last_step_s = 1'b0;
      case (state_r)
         ST_IDLE: begin
            // start_ready is high throughout IDLE, so start_valid alone
            // completes the operand handshake here.
            if (bus.start_valid) begin
               accept_s    = 1'b1;
               state_nxt_s = ST_RUN;
            end else begin
               state_nxt_s = ST_IDLE;
            end
         end
         ST_RUN: begin
            if (cnt_r == CNT_LAST) begin
               last_step_s = 1'b1;
               state_nxt_s = ST_DONE;
            end else begin
               state_nxt_s = ST_RUN;
            end
         end
         ST_DONE: begin
            if (bus.result_ready) begin
               state_nxt_s = ST_IDLE;
            end else begin
               state_nxt_s = ST_DONE;
            end
         end
         default: begin
            state_nxt_s = ST_IDLE;
         end
      endcase
   end

   // Handshake/status outputs registered from the next state so they are
   // glitch-free and exactly track the state register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         start_ready_r  <= 1'b1;
         result_valid_r <= 1'b0;
         busy_r         <= 1'b0;
      end else begin
         start_ready_r  <= (state_nxt_s == ST_IDLE);
         result_valid_r <= (state_nxt_s == ST_DONE);
         busy_r         <= (state_nxt_s == ST_RUN) || (state_nxt_s == ST_DONE);
      end
   end

   // Operand shift registers, rippled carry, sum accumulator and bit counter
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_r    <= '0;
         a_sh_r   <= '0;
         b_sh_r   <= '0;
         sum_sh_r <= '0;
         carry_r  <= 1'b0;
      end else if (accept_s) begin
         a_sh_r  <= bus.a;
         b_sh_r  <= bus.b;
         carry_r <= bus.cin;
         cnt_r   <= '0;
      end else if (state_r == ST_RUN) begin
         // Sum bits enter at the MSB end so after WIDTH steps bit 0 of the
         // add has reached sum_sh_r[0].
         sum_sh_r <= {fa_sum, sum_sh_r[WIDTH-1:1]};
         carry_r  <= fa_cout;
         a_sh_r   <= {1'b0, a_sh_r[WIDTH-1:1]};
         b_sh_r   <= {1'b0, b_sh_r[WIDTH-1:1]};
         // Counter parks at zero after the last step so it never passes
         // WIDTH-1.
         cnt_r    <= last_step_s ? {CNT_W{1'b0}} : (cnt_r + CNT_ONE);
      end
   end

`ifdef SERIAL_ADDER_OVF_EN
   logic ovf_r;

   // Signed overflow: carry into the MSB (fa_cin == carry_r) XOR carry out of it
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ovf_r <= 1'b0;
      end else if (last_step_s) begin
         ovf_r <= fa_cout ^ carry_r;
      end
   end

   assign bus.ovf = ovf_r;
`else
   assign bus.ovf = 1'b0;
`endif

   // Full adder inputs are gated by the registered state only, so there is
   // no combinational path from start_valid to the adder.
   assign fa_in1 = (state_r == ST_RUN) ? a_sh_r[0] : 1'b0;
   assign fa_in2 = (state_r == ST_RUN) ? b_sh_r[0] : 1'b0;
   assign fa_cin = (state_r == ST_RUN) ? carry_r   : 1'b0;

   assign bus.start_ready  = start_ready_r;
   assign bus.result_valid = result_valid_r;
   assign bus.sum          = sum_sh_r;
   assign bus.cout         = carry_r;
   assign busy             = busy_r;

endmodule : serial_adder_ctrl

// File: tb/tb_serial_adder_ctrl.sv
// ----------------------------------------------------------------------------
// tb_serial_adder_ctrl
//   Scoreboard bench for serial_adder_ctrl (WIDTH=8). The full adder is
//   modelled here; expected results come from integer arithmetic on the
//   operands and are queued on accept, a monitor pops them on every result
//   handshake.
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_serial_adder_ctrl;

   localparam int W = 8;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic fa_in1, fa_in2, fa_cin, fa_sum, fa_cout, busy;

   serial_adder_ctrl_if #(.WIDTH(W)) bus ();

   serial_adder_ctrl #(.WIDTH(W)) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .bus     (bus),
      .fa_in1  (fa_in1),
      .fa_in2  (fa_in2),
      .fa_cin  (fa_cin),
      .fa_sum  (fa_sum),
      .fa_cout (fa_cout),
      .busy    (busy)
   );

   // external 1-bit full adder
   assign fa_sum  = fa_in1 ^ fa_in2 ^ fa_cin;
   assign fa_cout = (fa_in1 & fa_in2) | (fa_in1 & fa_cin) | (fa_in2 & fa_cin);

   always #5 clk = ~clk;

   int n_vec  = 0;
   int n_fail = 0;
   int cyc    = 0;
   int last_acc = -1;
   logic [W+1:0] exp_q[$];   // {ovf, cout, sum}

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference: plain integer addition, signed range check for overflow
   function automatic logic [W+1:0] model(input int a, input int b, input int c);
      int s;
      int sa;
      int sb;
      logic [W:0] s_bits;
      logic o;
      s      = a + b + c;
      s_bits = s[W:0];
      o      = 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
      sa = (a >= (1 << (W-1))) ? a - (1 << W) : a;
      sb = (b >= (1 << (W-1))) ? b - (1 << W) : b;
      o  = ((sa + sb + c) > ((1 << (W-1)) - 1)) || ((sa + sb + c) < -(1 << (W-1)));
`endif
      return {o, s_bits};
   endfunction

   // carry into bit i of a+b+c
   function automatic logic carry_into(input int a, input int b, input int c, input int i);
      int m;
      m = (1 << i) - 1;
      return ((((a & m) + (b & m) + c) >> i) & 1) != 0;
   endfunction

   // Monitor: compare each presented result against the queue head
   always @(negedge clk) begin
      logic [W+1:0] e;
      if (rst_n && bus.result_valid && bus.result_ready) begin
         if (exp_q.size() == 0) begin
            chk("unexpected_result", 32'(bus.result_valid), 32'd0);
         end else begin
            e = exp_q.pop_front();
            chk("sum",  32'(bus.sum),  32'(e[W-1:0]));
            chk("cout", 32'(bus.cout), 32'(e[W]));
            chk("ovf",  32'(bus.ovf),  32'(e[W+1]));
         end
      end
   end

   // Present operands, wait for acceptance, queue the expectation.
   // Returns 1 ns after the accepting edge.
   task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic c);
      int k;
      bus.a = a; bus.b = b; bus.cin = c; bus.start_valid = 1'b1;
      k = 0;
      @(negedge clk);
      while (!bus.start_ready && k < 100) begin
         @(negedge clk);
         k++;
      end
      if (!bus.start_ready) begin
         chk("accept_timeout", 32'd1, 32'd0);
      end else begin
         exp_q.push_back(model(int'(a), int'(b), int'(c)));
         if (last_acc >= 0) chk("throughput", 32'(cyc - last_acc), 32'(W + 2));
         last_acc = cyc;
      end
      @(posedge clk); #1;
      bus.start_valid = 1'b0;
   endtask

   task automatic drain();
      int k;
      k = 0;
      while (exp_q.size() != 0 && k < 200) begin
         @(posedge clk); #1;
         k++;
      end
      chk("drain", 32'(exp_q.size()), 32'd0);
   endtask

   task automatic chk_idle_outputs(input string tag);
      chk({tag, "_start_ready"},  32'(bus.start_ready),  32'd1);
      chk({tag, "_result_valid"}, 32'(bus.result_valid), 32'd0);
      chk({tag, "_busy"},         32'(busy),             32'd0);
      chk({tag, "_fa"},           32'({fa_in1, fa_in2, fa_cin}), 32'd0);
      chk({tag, "_sum"},          32'(bus.sum),          32'd0);
      chk({tag, "_cout"},         32'(bus.cout),         32'd0);
      chk({tag, "_ovf"},          32'(bus.ovf),          32'd0);
   endtask

   initial begin
      int k;
      logic [W-1:0] ra, rb;
      logic [W+1:0] e;
      bus.start_valid = 1'b0; bus.a = '0; bus.b = '0; bus.cin = 1'b0;
      bus.result_ready = 1'b1;
      #12;
      chk_idle_outputs("reset");
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;

      // 0+0: latency from accept edge to result_valid
      issue(8'h00, 8'h00, 1'b0);
      k = 1;
      while (k < 20) begin
         @(posedge clk); #1;
         if (bus.result_valid) break;
         k++;
      end
      chk("latency", 32'(k), 32'(W));
      drain();
      last_acc = -1;

      // FF+01: carry chain seen on fa_cin across the RUN cycles
      issue(8'hFF, 8'h01, 1'b0);
      for (int i = 0; i < W; i++) begin
         chk("fa_cin_trace", 32'(fa_cin), 32'(carry_into(255, 1, 0, i)));
         chk("busy_run", 32'(busy), 32'd1);
         @(posedge clk); #1;
      end
      drain();
      last_acc = -1;

      // 7F+01: signed overflow case
      issue(8'h7F, 8'h01, 1'b0);
      drain();
      last_acc = -1;

      // Backpressure with an ignored start pulse
      bus.result_ready = 1'b0;
      issue(8'h3C, 8'hC5, 1'b1);
      e = model(8'h3C, 8'hC5, 1);
      k = 0;
      while (!bus.result_valid && k < 20) begin
         @(posedge clk); #1;
         k++;
      end
      chk("bp_valid", 32'(bus.result_valid), 32'd1);
      for (int i = 0; i < 5; i++) begin
         bus.a = 8'h11; bus.b = 8'h22; bus.cin = 1'b0;
         bus.start_valid = (i == 1 || i == 2);
         chk("bp_sum",         32'(bus.sum),          32'(e[W-1:0]));
         chk("bp_cout",        32'(bus.cout),         32'(e[W]));
         chk("bp_start_ready", 32'(bus.start_ready),  32'd0);
         chk("bp_hold_valid",  32'(bus.result_valid), 32'd1);
         @(posedge clk); #1;
      end
      bus.start_valid  = 1'b0;
      bus.result_ready = 1'b1;
      @(posedge clk); #1;
      chk("bp_release_ready", 32'(bus.start_ready),  32'd1);
      chk("bp_release_valid", 32'(bus.result_valid), 32'd0);
      drain();
      last_acc = -1;

      // Reset during RUN cycle 3 aborts the add
      issue(8'hAA, 8'h55, 1'b0);
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst_n = 1'b0;
      void'(exp_q.pop_back());
      #1;
      chk_idle_outputs("midrun_reset");
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
      last_acc = -1;
      issue(8'h12, 8'h34, 1'b1);
      drain();
      last_acc = -1;

      // Random back-to-back adds
      for (int i = 0; i < 500; i++) begin
         ra = W'($urandom);
         rb = W'($urandom);
         issue(ra, rb, 1'($urandom_range(1, 0)));
      end
      drain();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule : tb_serial_adder_ctrl
